id_ex_pipe_reg: RTL
===================

Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register sitting directly downstream of the ID-stage control unit.
- Captures decoded control bits, operands and register indices each cycle and presents them to EX as *_EX outputs.
- Owns load-use hazard detection and bubble insertion, and honours an external hold and a branch/jump flush.
- Counts inserted bubbles for performance monitoring.

Parameters:
XLEN, 32, datapath width (PC, operands, immediate)
REG_AW, 5, register index width
CNT_W, 32, bubble counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
valid_ID  in  1  ID holds a real instruction
reg_write_ID  in  1  control from decode
result_sel_ID  in  2  0 ALU, 1 load data, 2 PC+4
mem_write_ID  in  1  store
uncond_jump_ID  in  1  JAL/JALR
meet_branch_ID  in  1  conditional branch
alu_ctrl_ID  in  1  ALU op select
alu_sel_0_ID  in  2  0 rs1, 1 PC, 2 zero
alu_sel_1_ID  in  2  0 rs2, 1 imm
pc_jal_sel_ID  in  1  JALR target select
funct3_ID  in  3  branch/mem size
rs1_ID, rs2_ID, rd_ID  in  REG_AW each  register indices
rs1_data_ID, rs2_data_ID, imm_ID, pc_ID, pc_plus4_ID  in  XLEN each  operands
hold_EX  in  1  external stall: freeze EX register
flush_EX  in  1  taken branch/jump: kill the ID instruction
(every *_ID input above has a matching *_EX output of the same width)
valid_EX  out  1  EX holds a real instruction
stall_front  out  1  load-use stall request to PC and IF/ID
bubble_cnt  out  CNT_W  bubbles inserted since reset

Behaviour:
- Reset (async, immediate): all *_EX outputs 0, valid_EX 0, bubble_cnt 0. stall_front is combinational and therefore 0 while reset is asserted.
- Load-use detect (combinational):
  - ex_load = valid_EX & reg_write_EX & (result_sel_EX==1) & (rd_EX!=0).
  - rs1_used = (alu_sel_0_ID==0) | meet_branch_ID.
  - rs2_used = (alu_sel_1_ID==0) | mem_write_ID | meet_branch_ID.
  - lu = valid_ID & ex_load & ((rs1_used & rs1_ID==rd_EX) | (rs2_used & rs2_ID==rd_EX)).
  - stall_front = lu & ~flush_EX & ~hold_EX.
- Per-edge priority, highest first:
  1. flush_EX: load bubble.
  2. hold_EX: retain all EX contents; counter unchanged.
  3. lu: load bubble. Upstream holds the same ID instruction, which re-evaluates next cycle with lu=0.
  4. Otherwise: capture all *_ID inputs, valid_EX <= valid_ID.
- Bubble:
  - valid_EX=0; reg_write, mem_write, uncond_jump, meet_branch, result_sel all 0.
  - Datapath/index fields are loaded with 0.
  - bubble_cnt += 1, saturating at all-ones.
- Latency: exactly 1 cycle ID->EX. A single load-use costs exactly one bubble.
- valid_ID=0 on a normal edge: the fields are captured as-is, but valid_EX=0 and all four write/branch/jump controls are forced to 0. This is not counted as a bubble.
- Edge cases:
  - rd_EX==0 never triggers a stall.
  - Simultaneous flush and lu: flush wins and stall_front=0.
  - Simultaneous hold and flush: flush wins.
  - Reset mid-stall: all state clears and stall_front drops in the same cycle.

Decomposition:
- Shared package/header (with the existing opcode defines):
  - RESULT_ALU/LOAD/PC4 encodings (0/1/2).
  - ALU_SRC0_RS1/PC/ZERO and ALU_SRC1_RS2/IMM encodings.
  - XLEN and REG_AW defaults.
- One natural sub-module: load_use_detect, which is purely combinational and produces lu. The register and the counter stay in the top module.

Test Plan:
- Normal flow: add x3,x1,x2 (reg_write=1, alu_sel_1=0, rd=3, valid_ID=1) -> next edge: reg_write_EX=1, rd_EX=3, valid_EX=1, stall_front=0.
- Load-use: EX holds lw x5 (result_sel_EX=1, rd_EX=5), ID holds add x6,x5,x1 -> stall_front=1; next edge valid_EX=0, bubble_cnt=1; following edge the add is captured, stall_front=0.
- rd_EX=0 load, or ID is addi x6,x7,4 reading only rs1=7 with rd_EX=5 (also a store with rs2=5 but mem_write=0 and alu_sel_1=1) -> stall_front=0 and no bubble.
- Flush priority: flush_EX=1 together with lu=1 -> stall_front=0, EX becomes a bubble, bubble_cnt +1 (exactly once).
- Hold: hold_EX=1 for 3 cycles while ID inputs change -> every *_EX output unchanged, bubble_cnt unchanged, stall_front=0.
- Async reset: assert rst between edges during a stall -> outputs 0 immediately (before next clk). Counter-saturation check with CNT_W=4: 20 bubbles -> bubble_cnt=15.

Source files
------------

// File: rtl/id_ex_pipe_reg_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg_pkg
// Shared definitions for the ID/EX pipeline register slice.
//   - default datapath / register-index / counter widths
//   - result-mux and ALU-source encodings produced by the ID control unit
//   - base opcode values used by the decoder
//   - small helpers describing which source registers an instruction reads
// ---------------------------------------------------------------------------
package id_ex_pipe_reg_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;
  localparam int CNT_W_DEF  = 32;

  // Write-back result select
  typedef enum logic [1:0] {
    RESULT_ALU  = 2'd0,
    RESULT_LOAD = 2'd1,
    RESULT_PC4  = 2'd2
  } result_sel_e;

  // ALU operand A source
  typedef enum logic [1:0] {
    ALU_SRC0_RS1  = 2'd0,
    ALU_SRC0_PC   = 2'd1,
    ALU_SRC0_ZERO = 2'd2
  } alu_src0_e;

  // ALU operand B source
  typedef enum logic [1:0] {
    ALU_SRC1_RS2 = 2'd0,
    ALU_SRC1_IMM = 2'd1
  } alu_src1_e;

  // Base opcodes (RV32I)
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Write-back comes from memory, i.e. the value is not ready until MEM.
  function automatic logic is_load_result(input logic [1:0] result_sel);
    return (result_sel == RESULT_LOAD);
  endfunction

  // rs1 is consumed when it feeds ALU operand A or the branch comparator.
  function automatic logic reads_rs1(input logic [1:0] alu_sel_0,
                                     input logic       meet_branch);
    return (alu_sel_0 == ALU_SRC0_RS1) | meet_branch;
  endfunction

  // rs2 is consumed by ALU operand B, as store data, or by the comparator.
  function automatic logic reads_rs2(input logic [1:0] alu_sel_1,
                                     input logic       mem_write,
                                     input logic       meet_branch);
    return (alu_sel_1 == ALU_SRC1_RS2) | mem_write | meet_branch;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg_if
// Bundle between the ID stage (master side: decoder / hazard consumers) and
// the ID/EX pipeline register (slave side).
//   *_ID          decoded fields of the instruction currently in ID
//   hold_EX       external stall, freezes the EX register
//   flush_EX      taken branch/jump, kills the ID instruction
//   *_EX          registered copy presented to the EX stage
//   stall_front   load-use stall request to PC and IF/ID
//   bubble_cnt    number of bubbles inserted since reset
// ---------------------------------------------------------------------------
interface id_ex_pipe_reg_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);

  // ID side
  logic              valid_ID;
  logic              reg_write_ID;
  logic [1:0]        result_sel_ID;
  logic              mem_write_ID;
  logic              uncond_jump_ID;
  logic              meet_branch_ID;
  logic              alu_ctrl_ID;
  logic [1:0]        alu_sel_0_ID;
  logic [1:0]        alu_sel_1_ID;
  logic              pc_jal_sel_ID;
  logic [2:0]        funct3_ID;
  logic [REG_AW-1:0] rs1_ID;
  logic [REG_AW-1:0] rs2_ID;
  logic [REG_AW-1:0] rd_ID;
  logic [XLEN-1:0]   rs1_data_ID;
  logic [XLEN-1:0]   rs2_data_ID;
  logic [XLEN-1:0]   imm_ID;
  logic [XLEN-1:0]   pc_ID;
  logic [XLEN-1:0]   pc_plus4_ID;
  logic              hold_EX;
  logic              flush_EX;

  // EX side
  logic              valid_EX;
  logic              reg_write_EX;
  logic [1:0]        result_sel_EX;
  logic              mem_write_EX;
  logic              uncond_jump_EX;
  logic              meet_branch_EX;
  logic              alu_ctrl_EX;
  logic [1:0]        alu_sel_0_EX;
  logic [1:0]        alu_sel_1_EX;
  logic              pc_jal_sel_EX;
  logic [2:0]        funct3_EX;
  logic [REG_AW-1:0] rs1_EX;
  logic [REG_AW-1:0] rs2_EX;
  logic [REG_AW-1:0] rd_EX;
  logic [XLEN-1:0]   rs1_data_EX;
  logic [XLEN-1:0]   rs2_data_EX;
  logic [XLEN-1:0]   imm_EX;
  logic [XLEN-1:0]   pc_EX;
  logic [XLEN-1:0]   pc_plus4_EX;
  logic              stall_front;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output valid_ID, reg_write_ID, result_sel_ID, mem_write_ID, uncond_jump_ID,
           meet_branch_ID, alu_ctrl_ID, alu_sel_0_ID, alu_sel_1_ID, pc_jal_sel_ID,
           funct3_ID, rs1_ID, rs2_ID, rd_ID, rs1_data_ID, rs2_data_ID, imm_ID,
           pc_ID, pc_plus4_ID, hold_EX, flush_EX,
    input  valid_EX, reg_write_EX, result_sel_EX, mem_write_EX, uncond_jump_EX,
           meet_branch_EX, alu_ctrl_EX, alu_sel_0_EX, alu_sel_1_EX, pc_jal_sel_EX,
           funct3_EX, rs1_EX, rs2_EX, rd_EX, rs1_data_EX, rs2_data_EX, imm_EX,
           pc_EX, pc_plus4_EX, stall_front, bubble_cnt
  );

  modport slave (
    input  valid_ID, reg_write_ID, result_sel_ID, mem_write_ID, uncond_jump_ID,
           meet_branch_ID, alu_ctrl_ID, alu_sel_0_ID, alu_sel_1_ID, pc_jal_sel_ID,
           funct3_ID, rs1_ID, rs2_ID, rd_ID, rs1_data_ID, rs2_data_ID, imm_ID,
           pc_ID, pc_plus4_ID, hold_EX, flush_EX,
    output valid_EX, reg_write_EX, result_sel_EX, mem_write_EX, uncond_jump_EX,
           meet_branch_EX, alu_ctrl_EX, alu_sel_0_EX, alu_sel_1_EX, pc_jal_sel_EX,
           funct3_EX, rs1_EX, rs2_EX, rd_EX, rs1_data_EX, rs2_data_EX, imm_EX,
           pc_EX, pc_plus4_EX, stall_front, bubble_cnt
  );

endinterface

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg_load_use_detect
// Purely combinational load-use hazard detector.
//   i_valid_id        ID holds a real instruction
//   i_alu_sel_0_id    ALU operand A source of the ID instruction
//   i_alu_sel_1_id    ALU operand B source of the ID instruction
//   i_mem_write_id    ID instruction is a store
//   i_meet_branch_id  ID instruction is a conditional branch
//   i_rs1_id/i_rs2_id source register indices in ID
//   i_valid_ex        EX holds a real instruction
//   i_reg_write_ex    EX instruction writes the register file
//   i_result_sel_ex   EX write-back source
//   i_rd_ex           EX destination register
//   o_lu              ID consumes a register still being loaded in EX
// ---------------------------------------------------------------------------
module id_ex_pipe_reg_load_use_detect
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              i_valid_id,
  input  logic [1:0]        i_alu_sel_0_id,
  input  logic [1:0]        i_alu_sel_1_id,
  input  logic              i_mem_write_id,
  input  logic              i_meet_branch_id,
  input  logic [REG_AW-1:0] i_rs1_id,
  input  logic [REG_AW-1:0] i_rs2_id,
  input  logic              i_valid_ex,
  input  logic              i_reg_write_ex,
  input  logic [1:0]        i_result_sel_ex,
  input  logic [REG_AW-1:0] i_rd_ex,
  output logic              o_lu
);

  logic w_ex_load;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // Hazard decision: a real load to a non-x0 register in EX whose rd is read in ID
  always_comb begin
    w_ex_load = i_valid_ex & i_reg_write_ex & is_load_result(i_result_sel_ex)
              & (i_rd_ex != {REG_AW{1'b0}});
    w_rs1_hit = reads_rs1(i_alu_sel_0_id, i_meet_branch_id) & (i_rs1_id == i_rd_ex);
    w_rs2_hit = reads_rs2(i_alu_sel_1_id, i_mem_write_id, i_meet_branch_id)
              & (i_rs2_id == i_rd_ex);
    if (i_valid_id && w_ex_load) begin
      o_lu = w_rs1_hit | w_rs2_hit;
    end else begin
      o_lu = 1'b0;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
// ID/EX pipeline register with load-use bubble insertion.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   id_ex_pipe_reg_if.slave: *_ID inputs, hold_EX, flush_EX in;
//         *_EX, valid_EX, stall_front, bubble_cnt out
// Edge priority: flush -> bubble, hold -> freeze, load-use -> bubble,
// otherwise capture ID. Every bubble bumps a saturating counter.
// ---------------------------------------------------------------------------
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  id_ex_pipe_reg_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [1:0]        result_sel;
    logic              mem_write;
    logic              uncond_jump;
    logic              meet_branch;
    logic              alu_ctrl;
    logic [1:0]        alu_sel_0;
    logic [1:0]        alu_sel_1;
    logic              pc_jal_sel;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
  } ex_fields_t;

  ex_fields_t       r_ex;
  ex_fields_t       w_capture;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_lu;
  logic             w_stall_front;
  logic             w_bubble;

  id_ex_pipe_reg_load_use_detect #(
    .REG_AW (REG_AW)
  ) u_load_use_detect (
    .i_valid_id       (bus.valid_ID),
    .i_alu_sel_0_id   (bus.alu_sel_0_ID),
    .i_alu_sel_1_id   (bus.alu_sel_1_ID),
    .i_mem_write_id   (bus.mem_write_ID),
    .i_meet_branch_id (bus.meet_branch_ID),
    .i_rs1_id         (bus.rs1_ID),
    .i_rs2_id         (bus.rs2_ID),
    .i_valid_ex       (r_ex.valid),
    .i_reg_write_ex   (r_ex.reg_write),
    .i_result_sel_ex  (r_ex.result_sel),
    .i_rd_ex          (r_ex.rd),
    .o_lu             (w_lu)
  );

  // A stall is only requested when the load-use bubble actually wins the edge
  assign w_stall_front = w_lu & ~bus.flush_EX & ~bus.hold_EX;
  assign w_bubble      = bus.flush_EX | w_stall_front;

  // Capture image of the ID instruction; an invalid slot keeps its fields
  // but may never write state or redirect the PC
  always_comb begin
    w_capture             = '0;
    w_capture.valid       = bus.valid_ID;
    w_capture.result_sel  = bus.result_sel_ID;
    w_capture.alu_ctrl    = bus.alu_ctrl_ID;
    w_capture.alu_sel_0   = bus.alu_sel_0_ID;
    w_capture.alu_sel_1   = bus.alu_sel_1_ID;
    w_capture.pc_jal_sel  = bus.pc_jal_sel_ID;
    w_capture.funct3      = bus.funct3_ID;
    w_capture.rs1         = bus.rs1_ID;
    w_capture.rs2         = bus.rs2_ID;
    w_capture.rd          = bus.rd_ID;
    w_capture.rs1_data    = bus.rs1_data_ID;
    w_capture.rs2_data    = bus.rs2_data_ID;
    w_capture.imm         = bus.imm_ID;
    w_capture.pc          = bus.pc_ID;
    w_capture.pc_plus4    = bus.pc_plus4_ID;
    if (bus.valid_ID) begin
      w_capture.reg_write   = bus.reg_write_ID;
      w_capture.mem_write   = bus.mem_write_ID;
      w_capture.uncond_jump = bus.uncond_jump_ID;
      w_capture.meet_branch = bus.meet_branch_ID;
    end else begin
      w_capture.reg_write   = 1'b0;
      w_capture.mem_write   = 1'b0;
      w_capture.uncond_jump = 1'b0;
      w_capture.meet_branch = 1'b0;
    end
  end

  // Saturating increment for the bubble counter
  always_comb begin
    if (&r_bubble_cnt) begin
      w_cnt_next = r_bubble_cnt;
    end else begin
      w_cnt_next = r_bubble_cnt + CNT_ONE;
    end
  end

  // EX register and bubble counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex         <= '0;
      r_bubble_cnt <= {CNT_W{1'b0}};
    end else if (w_bubble) begin
      // Flush beats hold; a bubble clears every field, not just valid
      r_ex         <= '0;
      r_bubble_cnt <= w_cnt_next;
    end else if (bus.hold_EX) begin
      r_ex         <= r_ex;
      r_bubble_cnt <= r_bubble_cnt;
    end else begin
      r_ex         <= w_capture;
      r_bubble_cnt <= r_bubble_cnt;
    end
  end

  assign bus.valid_EX       = r_ex.valid;
  assign bus.reg_write_EX   = r_ex.reg_write;
  assign bus.result_sel_EX  = r_ex.result_sel;
  assign bus.mem_write_EX   = r_ex.mem_write;
  assign bus.uncond_jump_EX = r_ex.uncond_jump;
  assign bus.meet_branch_EX = r_ex.meet_branch;
  assign bus.alu_ctrl_EX    = r_ex.alu_ctrl;
  assign bus.alu_sel_0_EX   = r_ex.alu_sel_0;
  assign bus.alu_sel_1_EX   = r_ex.alu_sel_1;
  assign bus.pc_jal_sel_EX  = r_ex.pc_jal_sel;
  assign bus.funct3_EX      = r_ex.funct3;
  assign bus.rs1_EX         = r_ex.rs1;
  assign bus.rs2_EX         = r_ex.rs2;
  assign bus.rd_EX          = r_ex.rd;
  assign bus.rs1_data_EX    = r_ex.rs1_data;
  assign bus.rs2_data_EX    = r_ex.rs2_data;
  assign bus.imm_EX         = r_ex.imm;
  assign bus.pc_EX          = r_ex.pc;
  assign bus.pc_plus4_EX    = r_ex.pc_plus4;
  assign bus.stall_front    = w_stall_front;
  assign bus.bubble_cnt     = r_bubble_cnt;

endmodule
